// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM encoding and
// the per-command context latched at accept time.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 4;
    localparam int unsigned REG_CNT    = 4;
    localparam int unsigned REG_AW     = 2;
    localparam int unsigned OP_W       = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_OR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR = 3'b101;
    localparam logic [OP_W-1:0] OP_LT  = 3'b110;
    localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic                  ld;
        logic [REG_AW-1:0]     rd;
        logic [ALU_DATA_W-1:0] imm;
    } cmd_ctx_t;

    // Only add/sub report carry and overflow into the sticky flags.
    function automatic logic is_flag_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Compare ops return a single bit through the ALU's alu_out port.
    function automatic logic is_cmp_op(input logic [OP_W-1:0] op);
        return (op == OP_LT) || (op == OP_EQ);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Four-entry register file: one write port, two operand read ports and one
// debug read port, all reads combinational.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [REG_AW-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [REG_AW-1:0]   rs1_addr,
    output logic [DATA_W-1:0]   rs1_data,
    input  logic [REG_AW-1:0]   rs2_addr,
    output logic [DATA_W-1:0]   rs2_data,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rs1_data = regs_q[rs1_addr];
    assign rs2_data = regs_q[rs2_addr];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external ALU: accepts one command every three
// cycles, drives registered ALU operands and writes the result back.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_ld,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [REG_AW-1:0]   cmd_rd,
    input  logic [REG_AW-1:0]   cmd_rs1,
    input  logic [REG_AW-1:0]   cmd_rs2,
    input  logic [DATA_W-1:0]   cmd_imm,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_opcode,
    input  logic [DATA_W-1:0]   alu_out_s,
    input  logic                alu_out_c,
    input  logic                alu_overflow,
    input  logic                alu_out,
    output logic                done_valid,
    output logic [DATA_W-1:0]   done_data,
    output logic                flag_c,
    output logic                flag_v,
    output logic                flag_z,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    state_e             state_q, state_d;
    cmd_ctx_t           ctx_q, ctx_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [OP_W-1:0]    alu_opcode_q, alu_opcode_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_v_q, flag_v_d;
    logic               flag_z_q, flag_z_d;
    logic               done_valid_q, done_valid_d;
    logic [DATA_W-1:0]  done_data_q, done_data_d;
    logic               cmd_ready_q, cmd_ready_d;

    logic               accept_c;
    logic               wr_en_c;
    logic [DATA_W-1:0]  wr_data_c;
    logic [DATA_W-1:0]  rs1_data_c;
    logic [DATA_W-1:0]  rs2_data_c;

    alu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_c),
        .wr_addr  (ctx_q.rd),
        .wr_data  (wr_data_c),
        .rs1_addr (cmd_rs1),
        .rs1_data (rs1_data_c),
        .rs2_addr (cmd_rs2),
        .rs2_data (rs2_data_c),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign accept_c = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);

    // Write-back happens at the edge that ends EXEC; ALU inputs are stable by then.
    assign wr_en_c = (state_q == ST_EXEC);

    always_comb begin
        if (ctx_q.ld) begin
            wr_data_c = ctx_q.imm;
        end else if (is_cmp_op(alu_opcode_q)) begin
            wr_data_c = DATA_W'(alu_out);
        end else begin
            wr_data_c = alu_out_s;
        end
    end

    always_comb begin
        state_d      = state_q;
        ctx_d        = ctx_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        flag_c_d     = flag_c_q;
        flag_v_d     = flag_v_q;
        flag_z_d     = flag_z_q;
        done_valid_d = 1'b0;
        done_data_d  = done_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    ctx_d        = '{ld: cmd_ld, rd: cmd_rd, imm: cmd_imm};
                    alu_a_d      = rs1_data_c;
                    alu_b_d      = rs2_data_c;
                    alu_opcode_d = cmd_op;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                done_valid_d = 1'b1;
                done_data_d  = wr_data_c;
                flag_z_d     = (wr_data_c == '0);
                if (!ctx_q.ld && is_flag_op(alu_opcode_q)) begin
                    flag_c_d = alu_out_c;
                    flag_v_d = alu_overflow;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ctx_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            flag_c_q     <= 1'b0;
            flag_v_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            done_valid_q <= 1'b0;
            done_data_q  <= '0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            ctx_q        <= ctx_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            flag_c_q     <= flag_c_d;
            flag_v_q     <= flag_v_d;
            flag_z_q     <= flag_z_d;
            done_valid_q <= done_valid_d;
            done_data_q  <= done_data_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign flag_c     = flag_c_q;
    assign flag_v     = flag_v_q;
    assign flag_z     = flag_z_q;
    assign done_valid = done_valid_q;
    assign done_data  = done_data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU stub plus an integer reference
// model of the register file and sticky flags.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_ld;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2, dbg_addr;
    logic [3:0] cmd_imm, alu_a, alu_b, alu_out_s, done_data, dbg_data;
    logic [2:0] alu_opcode;
    logic       alu_out_c, alu_overflow, alu_out;
    logic       done_valid, flag_c, flag_v, flag_z;

    int checks = 0;
    int errors = 0;

    int m_regs [4];
    int m_c, m_v, m_z;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(4)) dut (
        .clk (clk), .rst_n (rst_n),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_ld (cmd_ld),
        .cmd_op (cmd_op), .cmd_rd (cmd_rd), .cmd_rs1 (cmd_rs1), .cmd_rs2 (cmd_rs2),
        .cmd_imm (cmd_imm),
        .alu_a (alu_a), .alu_b (alu_b), .alu_opcode (alu_opcode),
        .alu_out_s (alu_out_s), .alu_out_c (alu_out_c), .alu_overflow (alu_overflow),
        .alu_out (alu_out),
        .done_valid (done_valid), .done_data (done_data),
        .flag_c (flag_c), .flag_v (flag_v), .flag_z (flag_z),
        .dbg_addr (dbg_addr), .dbg_data (dbg_data)
    );

    // External ALU stub; unused outputs carry decoy values so a wrong result mux shows up.
    logic [4:0] stub_sum;
    always_comb begin
        stub_sum     = 5'd0;
        alu_out_s    = 4'hA;
        alu_out_c    = 1'b0;
        alu_overflow = 1'b0;
        alu_out      = 1'b1;
        case (alu_opcode)
            OP_ADD: begin
                stub_sum     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out_s    = stub_sum[3:0];
                alu_out_c    = stub_sum[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (stub_sum[3] != alu_a[3]);
            end
            OP_SUB: begin
                stub_sum     = {1'b0, alu_a} - {1'b0, alu_b};
                alu_out_s    = stub_sum[3:0];
                alu_out_c    = stub_sum[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (stub_sum[3] != alu_a[3]);
            end
            OP_NOT: alu_out_s = ~alu_a;
            OP_AND: alu_out_s = alu_a & alu_b;
            OP_OR:  alu_out_s = alu_a | alu_b;
            OP_XOR: alu_out_s = alu_a ^ alu_b;
            OP_LT:  alu_out   = (alu_a < alu_b);
            OP_EQ:  alu_out   = (alu_a == alu_b);
            default: alu_out_s = 4'hA;
        endcase
    end

    function automatic int to_signed4(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_c = 0; m_v = 0; m_z = 0;
    endfunction

    // Reference: integer arithmetic on the architectural registers and flags.
    function automatic int model_exec(input int ld, input int op, input int rd,
                                      input int rs1, input int rs2, input int imm);
        int a, b, res, sres;
        a = m_regs[rs1];
        b = m_regs[rs2];
        res = 0;
        if (ld != 0) begin
            res = imm;
        end else begin
            case (op)
                0: begin
                    res  = (a + b) % 16;
                    m_c  = (a + b > 15) ? 1 : 0;
                    sres = to_signed4(a) + to_signed4(b);
                    m_v  = (sres > 7 || sres < -8) ? 1 : 0;
                end
                1: begin
                    res  = (a - b + 16) % 16;
                    m_c  = (a < b) ? 1 : 0;
                    sres = to_signed4(a) - to_signed4(b);
                    m_v  = (sres > 7 || sres < -8) ? 1 : 0;
                end
                2: res = 15 - a;
                3: res = a & b;
                4: res = a | b;
                5: res = a ^ b;
                6: res = (a < b) ? 1 : 0;
                default: res = (a == b) ? 1 : 0;
            endcase
        end
        m_z = (res == 0) ? 1 : 0;
        m_regs[rd] = res;
        return res;
    endfunction

    // Drives one command, waits for acceptance and records the done pulse.
    task automatic do_cmd(input int ld, input int op, input int rd, input int rs1,
                          input int rs2, input int imm, input bit junk,
                          output int data, output int lat, output int pulses);
        int w;
        lat = -1; pulses = 0; data = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ld = 1'(ld); cmd_op = 3'(op); cmd_rd = 2'(rd);
        cmd_rs1 = 2'(rs1); cmd_rs2 = 2'(rs2); cmd_imm = 4'(imm);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            checks++; errors++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (junk && i <= 2) begin
                cmd_valid = 1'($urandom); cmd_ld = 1'($urandom); cmd_op = 3'($urandom);
                cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom); cmd_rs2 = 2'($urandom);
                cmd_imm = 4'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            if (done_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = i;
                    data = int'(done_data);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = '0;
        cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; dbg_addr = '0;
        model_reset();
        #13;
        checks++;
        if ({done_valid, flag_c, flag_v, flag_z} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got %b required 0000", {done_valid, flag_c, flag_v, flag_z});
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode, done_data} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {alu_a, alu_b, alu_opcode, done_data});
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 4'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %0d required 0", i, dbg_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        int d, l, p, e;
        do_cmd(1, 0, 0, 0, 0, 7, 1'b0, d, l, p); e = model_exec(1, 0, 0, 0, 0, 7);
        do_cmd(1, 0, 1, 0, 0, 1, 1'b0, d, l, p); e = model_exec(1, 0, 1, 0, 0, 1);
        do_cmd(0, 0, 2, 0, 1, 0, 1'b0, d, l, p); e = model_exec(0, 0, 2, 0, 1, 0);
        checks++;
        if (d != e || e != 8) begin
            errors++; $display("FAIL add_data: got %0d required 8", d);
        end
        checks++;
        if (l != 2 || p != 1) begin
            errors++; $display("FAIL add_pulse: latency %0d width %0d required 2 and 1", l, p);
        end
        checks++;
        if ({flag_c, flag_v, flag_z} !== {1'(m_c), 1'(m_v), 1'(m_z)}) begin
            errors++; $display("FAIL add_flags: got cvz=%b%b%b required %0d%0d%0d",
                               flag_c, flag_v, flag_z, m_c, m_v, m_z);
        end
        dbg_addr = 2'd2; #1;
        checks++;
        if (dbg_data !== 4'(m_regs[2]) || done_data !== 4'(e)) begin
            errors++; $display("FAIL add_hold: r2=%0d done_data=%0d required %0d", dbg_data, done_data, e);
        end
    endtask

    task automatic test_sub();
        int d, l, p, e;
        do_cmd(1, 0, 0, 0, 0, 5, 1'b0, d, l, p); e = model_exec(1, 0, 0, 0, 0, 5);
        do_cmd(1, 0, 1, 0, 0, 5, 1'b0, d, l, p); e = model_exec(1, 0, 1, 0, 0, 5);
        do_cmd(0, 1, 3, 0, 1, 0, 1'b0, d, l, p); e = model_exec(0, 1, 3, 0, 1, 0);
        checks++;
        if (d != e || l != 2) begin
            errors++; $display("FAIL sub_data: got %0d at latency %0d required %0d at 2", d, l, e);
        end
        checks++;
        if ({flag_c, flag_v, flag_z} !== {1'(m_c), 1'(m_v), 1'b1}) begin
            errors++; $display("FAIL sub_flags: got cvz=%b%b%b required %0d%0d1", flag_c, flag_v, flag_z, m_c, m_v);
        end
    endtask

    task automatic test_compare();
        int d, l, p, e;
        do_cmd(1, 0, 0, 0, 0, 3, 1'b0, d, l, p); e = model_exec(1, 0, 0, 0, 0, 3);
        do_cmd(1, 0, 1, 0, 0, 9, 1'b0, d, l, p); e = model_exec(1, 0, 1, 0, 0, 9);
        do_cmd(0, 0, 3, 1, 1, 0, 1'b0, d, l, p); e = model_exec(0, 0, 3, 1, 1, 0);
        do_cmd(0, 6, 2, 0, 1, 0, 1'b0, d, l, p); e = model_exec(0, 6, 2, 0, 1, 0);
        checks++;
        if (d != e || e != 1) begin
            errors++; $display("FAIL lt_data: got %0d required 1", d);
        end
        do_cmd(0, 7, 2, 0, 1, 0, 1'b0, d, l, p); e = model_exec(0, 7, 2, 0, 1, 0);
        checks++;
        if (d != e || e != 0) begin
            errors++; $display("FAIL eq_data: got %0d required 0", d);
        end
        checks++;
        if ({flag_c, flag_v, flag_z} !== {1'(m_c), 1'(m_v), 1'b1} || m_c != 1 || m_v != 1) begin
            errors++; $display("FAIL cmp_flags: got cvz=%b%b%b required %0d%0d1", flag_c, flag_v, flag_z, m_c, m_v);
        end
    endtask

    task automatic test_back_to_back();
        int ld_t [4]  = '{1, 1, 0, 0};
        int op_t [4]  = '{0, 0, 0, 5};
        int rd_t [4]  = '{1, 2, 3, 0};
        int rs1_t [4] = '{0, 0, 1, 3};
        int rs2_t [4] = '{0, 0, 2, 1};
        int imm_t [4] = '{4, 11, 0, 0};
        int acc [4];
        int exp_q [$];
        int k = 0;
        int cyc = 0;
        while (cyc < 40 && (k < 4 || exp_q.size() > 0)) begin
            @(negedge clk);
            if (done_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || done_data !== 4'(exp_q[0])) begin
                    errors++; $display("FAIL b2b_data: got %0d required %0d", done_data,
                                       (exp_q.size() > 0) ? exp_q[0] : -1);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (k < 4) begin
                cmd_valid = 1'b1; cmd_ld = 1'(ld_t[k]); cmd_op = 3'(op_t[k]);
                cmd_rd = 2'(rd_t[k]); cmd_rs1 = 2'(rs1_t[k]); cmd_rs2 = 2'(rs2_t[k]);
                cmd_imm = 4'(imm_t[k]);
                if (cmd_ready === 1'b1) begin
                    acc[k] = cyc;
                    exp_q.push_back(model_exec(ld_t[k], op_t[k], rd_t[k], rs1_t[k], rs2_t[k], imm_t[k]));
                    k++;
                end
            end else begin
                cmd_valid = 1'b0;
            end
            cyc++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (k != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count: accepted %0d pending %0d required 4 and 0", k, exp_q.size());
        end
        for (int i = 1; i < k; i++) begin
            checks++;
            if (acc[i] - acc[0] != 3 * i) begin
                errors++; $display("FAIL b2b_spacing%0d: got %0d required %0d", i, acc[i] - acc[0], 3 * i);
            end
        end
    endtask

    task automatic test_random();
        int d, l, p, e, ld, op, rd, rs1, rs2, imm;
        for (int n = 0; n < 40; n++) begin
            ld = ($urandom_range(0, 2) == 0) ? 1 : 0;
            op = $urandom_range(0, 7); rd = $urandom_range(0, 3);
            rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3); imm = $urandom_range(0, 15);
            do_cmd(ld, op, rd, rs1, rs2, imm, 1'b1, d, l, p);
            e = model_exec(ld, op, rd, rs1, rs2, imm);
            checks++;
            if (d != e || l != 2 || p != 1) begin
                errors++; $display("FAIL rand%0d_data: got %0d lat %0d width %0d required %0d lat 2 width 1",
                                   n, d, l, p, e);
            end
            checks++;
            if ({flag_c, flag_v, flag_z} !== {1'(m_c), 1'(m_v), 1'(m_z)}) begin
                errors++; $display("FAIL rand%0d_flags: got cvz=%b%b%b required %0d%0d%0d",
                                   n, flag_c, flag_v, flag_z, m_c, m_v, m_z);
            end
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++;
            if (dbg_data !== 4'(m_regs[i])) begin
                errors++; $display("FAIL rand_reg%0d: got %0d required %0d", i, dbg_data, m_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d, l, p, e, pulses;
        do_cmd(1, 0, 2, 0, 0, 6, 1'b0, d, l, p); e = model_exec(1, 0, 2, 0, 0, 6);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = OP_ADD; cmd_rd = 2'd2;
        cmd_rs1 = 2'd2; cmd_rs2 = 2'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_valid !== 1'b0) pulses++;
        end
        dbg_addr = 2'd2; #1;
        checks++;
        if (dbg_data !== 4'(m_regs[2]) || pulses != 0) begin
            errors++; $display("FAIL midreset_r2: r2=%0d pulses=%0d required 0 and 0", dbg_data, pulses);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done_valid !== 1'b0 || flag_z !== 1'b0) begin
            errors++; $display("FAIL midreset_idle: ready=%b done=%b z=%b required 1 0 0", cmd_ready, done_valid, flag_z);
        end
        do_cmd(1, 0, 1, 0, 0, 3, 1'b0, d, l, p); e = model_exec(1, 0, 1, 0, 0, 3);
        checks++;
        if (d != e || l != 2 || p != 1) begin
            errors++; $display("FAIL midreset_resume: got %0d lat %0d required %0d lat 2", d, l, e);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
